// File: rtl/neopixel_strand_receiver.sv
// NeoPixel one-wire NRZ receiver: recovers bits from high-pulse widths, assembles 24-bit {G,R,B} pixels and detects the latch gap.
// Define NEO_RX_GLITCH_FILTER_EN to drop high pulses shorter than 4 clocks instead of decoding them as 0 bits.
module neopixel_strand_receiver #(
    parameter int NUM_PIXELS   = 5,
    parameter int T1_THRESH    = 26,
    parameter int HIGH_MAX     = 50,
    parameter int LATCH_CYCLES = 2500,
    parameter bit LSB_FIRST    = 1'b0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              neo_data,
    output logic [23:0]                       pixel_data,
    output logic [$clog2(NUM_PIXELS)-1:0]     pixel_index,
    output logic                              pixel_valid,
    output logic                              frame_done,
    output logic [$clog2(NUM_PIXELS+1)-1:0]   pixel_count,
    output logic                              overflow,
    output logic                              bit_error,
    output logic                              busy
);
    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int CNT_W = $clog2(NUM_PIXELS + 1);
    localparam int HC_W  = $clog2(HIGH_MAX + 2);
    localparam int LC_W  = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    logic              sync1_r, sync2_r, line_q_r, rise_r, fall_r;
    state_t            state_r, state_n;
    logic [HC_W-1:0]   high_cnt_r, high_cnt_n, high_inc_s;
    logic [LC_W-1:0]   low_cnt_r, low_cnt_n, low_inc_s;
    logic [4:0]        bit_cnt_r, bit_cnt_n;
    logic [23:0]       shift_r, shift_n, shifted_s;
    logic              bit_s, glitch_s, latch_s;
    logic [23:0]       pixel_data_r, pixel_data_n;
    logic [IDX_W-1:0]  pixel_index_r, pixel_index_n;
    logic              pixel_valid_r, pixel_valid_n;
    logic              frame_done_r, frame_done_n;
    logic [CNT_W-1:0]  pixel_count_r, pixel_count_n;
    logic              overflow_r, overflow_n;
    logic              bit_error_r, bit_error_n;
    logic              busy_r, busy_n;

    // Synchronizer and registered edge pulses; flops idle high so a line already high at reset release is not a rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            line_q_r <= 1'b1;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            sync1_r  <= neo_data;
            sync2_r  <= sync1_r;
            line_q_r <= sync2_r;
            rise_r   <= sync2_r & ~line_q_r;
            fall_r   <= ~sync2_r & line_q_r;
        end
    end

    // high_inc_s is the width of the current high pulse including this cycle.
    assign high_inc_s = (high_cnt_r == {HC_W{1'b1}}) ? high_cnt_r : high_cnt_r + HC_W'(1);
    assign low_inc_s  = low_cnt_r + LC_W'(1);
    assign latch_s    = (low_inc_s == LC_W'(LATCH_CYCLES));
    assign bit_s      = (high_inc_s >= HC_W'(T1_THRESH));
    assign shifted_s  = LSB_FIRST ? {bit_s, shift_r[23:1]} : {shift_r[22:0], bit_s};

`ifdef NEO_RX_GLITCH_FILTER_EN
    localparam int GLITCH_MIN = 4;
    assign glitch_s = (high_inc_s < HC_W'(GLITCH_MIN));
`else
    assign glitch_s = 1'b0;
`endif

    // Next-state and output logic for the pulse decoder.
    always_comb begin
        state_n       = state_r;
        high_cnt_n    = high_cnt_r;
        low_cnt_n     = low_cnt_r;
        bit_cnt_n     = bit_cnt_r;
        shift_n       = shift_r;
        pixel_data_n  = pixel_data_r;
        pixel_index_n = pixel_index_r;
        pixel_valid_n = 1'b0;
        frame_done_n  = 1'b0;
        pixel_count_n = pixel_count_r;
        overflow_n    = overflow_r;
        bit_error_n   = bit_error_r;
        busy_n        = busy_r;

        case (state_r)
            ST_IDLE: begin
                if (rise_r) begin
                    state_n       = ST_HIGH;
                    high_cnt_n    = '0;
                    low_cnt_n     = '0;
                    bit_cnt_n     = 5'd0;
                    shift_n       = 24'd0;
                    pixel_count_n = '0;
                    overflow_n    = 1'b0;
                    bit_error_n   = 1'b0;
                    busy_n        = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (high_inc_s > HC_W'(HIGH_MAX)) begin
                    bit_error_n = 1'b1;
                    low_cnt_n   = '0;
                    state_n     = ST_ERROR;
                end else if (fall_r && glitch_s) begin
                    // Glitch: back to LOW with the low counter untouched so the gap keeps accumulating.
                    state_n = ST_LOW;
                end else if (fall_r) begin
                    shift_n    = shifted_s;
                    low_cnt_n  = '0;
                    high_cnt_n = '0;
                    state_n    = ST_LOW;
                    if (bit_cnt_r == 5'd23) begin
                        bit_cnt_n = 5'd0;
                        if (pixel_count_r < CNT_W'(NUM_PIXELS)) begin
                            pixel_data_n  = shifted_s;
                            pixel_index_n = IDX_W'(pixel_count_r);
                            pixel_valid_n = 1'b1;
                            pixel_count_n = pixel_count_r + CNT_W'(1);
                        end else begin
                            overflow_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r + 5'd1;
                    end
                end else begin
                    high_cnt_n = high_inc_s;
                end
            end
            ST_LOW: begin
                if (rise_r) begin
                    high_cnt_n = '0;
                    state_n    = ST_HIGH;
                end else if (latch_s) begin
                    frame_done_n = 1'b1;
                    busy_n       = 1'b0;
                    state_n      = ST_IDLE;
                    bit_cnt_n    = 5'd0;
                    if (bit_cnt_r != 5'd0) begin
                        bit_error_n = 1'b1;
                    end else begin
                        bit_error_n = bit_error_r;
                    end
                end else begin
                    low_cnt_n = low_inc_s;
                end
            end
            ST_ERROR: begin
                if (sync2_r) begin
                    low_cnt_n = '0;
                end else if (latch_s) begin
                    frame_done_n = 1'b1;
                    busy_n       = 1'b0;
                    bit_cnt_n    = 5'd0;
                    state_n      = ST_IDLE;
                end else begin
                    low_cnt_n = low_inc_s;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            high_cnt_r    <= '0;
            low_cnt_r     <= '0;
            bit_cnt_r     <= 5'd0;
            shift_r       <= 24'd0;
            pixel_data_r  <= 24'd0;
            pixel_index_r <= '0;
            pixel_valid_r <= 1'b0;
            frame_done_r  <= 1'b0;
            pixel_count_r <= '0;
            overflow_r    <= 1'b0;
            bit_error_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            high_cnt_r    <= high_cnt_n;
            low_cnt_r     <= low_cnt_n;
            bit_cnt_r     <= bit_cnt_n;
            shift_r       <= shift_n;
            pixel_data_r  <= pixel_data_n;
            pixel_index_r <= pixel_index_n;
            pixel_valid_r <= pixel_valid_n;
            frame_done_r  <= frame_done_n;
            pixel_count_r <= pixel_count_n;
            overflow_r    <= overflow_n;
            bit_error_r   <= bit_error_n;
            busy_r        <= busy_n;
        end
    end

    assign pixel_data  = pixel_data_r;
    assign pixel_index = pixel_index_r;
    assign pixel_valid = pixel_valid_r;
    assign frame_done  = frame_done_r;
    assign pixel_count = pixel_count_r;
    assign overflow    = overflow_r;
    assign bit_error   = bit_error_r;
    assign busy        = busy_r;

endmodule
